// File: rtl/packet_rr_arbiter.sv
// Round-robin arbiter granting one output to whole packets from NUM_PORTS inputs.
// Header flits compete; the grant is held until length/tail ends the packet or the request drops.
module packet_rr_arbiter #(
    parameter int unsigned NUM_PORTS   = 5,
    parameter int unsigned LEN_W       = 12,
    parameter logic [2:0]  HEADER_CODE = 3'b001,
    parameter logic [2:0]  TAIL_CODE   = 3'b100
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_PORTS-1:0]         req,
    input  logic [3*NUM_PORTS-1:0]       flit_type,
    input  logic [LEN_W*NUM_PORTS-1:0]   length,
    input  logic                         out_ready,
    output logic [NUM_PORTS-1:0]         grant,
    output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
    output logic                         idle,
    output logic                         pkt_done,
    output logic                         len_err
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic                 idle_q, idle_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic [NUM_PORTS-1:0] elig;
    logic [IDX_W-1:0]     arb_base;
    logic [IDX_W-1:0]     cand;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_found;
    logic [LEN_W-1:0]     win_len;
    logic [LEN_W-1:0]     len_load;
    logic                 g_req;
    logic [2:0]           g_ft;
    logic                 is_last;
    logic                 is_tail;
    logic                 release_g;

    // Only header flits may win arbitration
    always_comb begin : elig_calc
        elig = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            elig[i] = req[i] && (flit_type[3*i +: 3] == HEADER_CODE);
        end
    end

    // While busy the search pivots on the port now finishing, so it lands last
    assign arb_base = (state_q == S_BUSY) ? idx_q : last_q;

    always_comb begin : arb_search
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned off = 1; off <= NUM_PORTS; off++) begin
            cand = IDX_W'((32'(arb_base) + off) % NUM_PORTS);
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_len  = length[LEN_W*win_idx +: LEN_W];
    assign len_load = (win_len == '0) ? LEN_W'(1) : win_len;
    assign g_req    = req[idx_q];
    assign g_ft     = flit_type[3*idx_q +: 3];
    assign is_last  = (rem_q == LEN_W'(1));
    assign is_tail  = (g_ft == TAIL_CODE);

    always_comb begin : next_state
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        rem_d     = rem_q;
        last_d    = last_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        release_g = 1'b0;

        case (state_q)
            S_IDLE: ;
            S_BUSY: begin
                if (!g_req) begin
                    release_g = 1'b1;
                    last_d    = idx_q;
                end else if (out_ready) begin
                    if (is_last || is_tail) begin
                        release_g = 1'b1;
                        last_d    = idx_q;
                        done_d    = 1'b1;
                        err_d     = is_last ^ is_tail;
                    end else begin
                        rem_d = rem_q - LEN_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Arbitrate from idle or directly at the edge that frees the output
        if (state_q == S_IDLE || release_g) begin
            if (win_found) begin
                state_d = S_BUSY;
                grant_d = NUM_PORTS'(1) << win_idx;
                idx_d   = win_idx;
                rem_d   = len_load;
            end else begin
                state_d = S_IDLE;
                grant_d = '0;
                idx_d   = '0;
                rem_d   = '0;
            end
        end

        idle_d = ~|grant_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            last_q  <= IDX_W'(NUM_PORTS - 1);
            idle_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
            idle_q  <= idle_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = idx_q;
    assign idle      = idle_q;
    assign pkt_done  = done_q;
    assign len_err   = err_q;

endmodule
